rps_match_ctrl: RTL and testbench
=================================

RPS_MATCH_CTRL -- requirements
Module: rps_match_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 3, meaning points needed to win the match (1..15).
REQ-002 SHALL have parameter REVEAL_CYCLES, default 1000, meaning clk cycles the result is held before the next round (>=1).
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port ready_p, input, 1, debounced one-cycle pulse that opens a round.
REQ-006 SHALL have port start_p, input, 1, debounced one-cycle pulse that closes selection and judges.
REQ-007 SHALL have port a_sel, input, 3, player A one-hot pulse: 100 rock, 010 scissors, 001 paper.
REQ-008 SHALL have port b_sel, input, 3, player B, same encoding as a_sel.
REQ-009 SHALL have port sel_open, output, 1, high while selections are accepted.
REQ-010 SHALL have port a_lock, output, 3, latched A choice (000 = none).
REQ-011 SHALL have port b_lock, output, 3, latched B choice (000 = none).
REQ-012 SHALL have port result, output, 2: 00 none, 01 A wins, 10 B wins, 11 draw.
REQ-013 SHALL have port result_vld, output, 1, one-cycle pulse when result updates.
REQ-014 SHALL have port incomplete, output, 1, one-cycle pulse when start_p is rejected.
REQ-015 SHALL have port score_a, output, 4, A's points.
REQ-016 SHALL have port score_b, output, 4, B's points.
REQ-017 SHALL have port match_over, output, 1, high once either score equals WIN_SCORE.

Function
REQ-018 SHALL implement FSM states IDLE, ARM, JUDGE, REVEAL, OVER.
REQ-019 IDLE: ready_p -> ARM next cycle, clearing a_lock, b_lock and result; start_p and selections ignored.
REQ-020 ARM: sel_open=1; a valid one-hot a_sel/b_sel SHALL load a_lock/b_lock next cycle, and a later valid selection SHALL overwrite it.
REQ-021 A selection with zero or more than one bit set SHALL be ignored in every state.
REQ-022 ARM + ready_p SHALL clear both locks and remain in ARM (re-arm); ready_p takes priority over start_p and over same-cycle selections.
REQ-023 ARM + start_p with both locks non-zero SHALL go to JUDGE; a selection arriving in the start_p cycle SHALL NOT be used.
REQ-024 ARM + start_p with either lock zero SHALL pulse incomplete next cycle and remain in ARM.
REQ-025 JUDGE lasts exactly one cycle: rock beats scissors, scissors beats paper, paper beats rock, equal choices give draw.
REQ-026 On leaving JUDGE, result SHALL be set, result_vld SHALL pulse once, and the winner's score SHALL increment by 1 (no change on draw), all in the same cycle.
REQ-027 Latency SHALL be 2 cycles from the accepted start_p edge to result_vld high.
REQ-028 REVEAL SHALL hold result, a_lock and b_lock for exactly REVEAL_CYCLES cycles, ignoring all inputs, then go to OVER if a score equals WIN_SCORE, else IDLE.
REQ-029 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-030 OVER: match_over=1, sel_open=0, all inputs ignored; only rst leaves OVER.
REQ-031 sel_open SHALL be 0 in every state except ARM.

Reset
REQ-032 rst sampled high at a clk edge SHALL force IDLE, a_lock=b_lock=000, result=00, result_vld=0, incomplete=0, score_a=score_b=0, match_over=0, sel_open=0, and clear the reveal counter.
REQ-033 rst SHALL take precedence over every input in every state, including mid-REVEAL and OVER.

Verification
REQ-034 rst, ready_p, a_sel=100, b_sel=010, start_p -> result_vld 2 cycles after start_p, result=01, score_a=1, score_b=0.
REQ-035 In ARM: a_sel=001 only, then start_p -> incomplete pulse, state stays ARM, scores unchanged; then b_sel=001, start_p -> result=11, scores unchanged.
REQ-036 In ARM: a_sel=011 and a_sel=100 then 010 -> a_lock=010; ready_p and start_p in the same cycle -> locks cleared, no judge.
REQ-037 With REVEAL_CYCLES=4: B wins three rounds -> score_b=3, match_over=1 exactly 4 cycles after the third result_vld; further ready_p/start_p produce no change.
REQ-038 rst asserted in the 2nd REVEAL cycle and in OVER -> all outputs at reset values next cycle, then a normal round plays correctly.

Source files
------------

// File: rtl/rps_match_ctrl.sv
// rps_match_ctrl: rock-paper-scissors match controller for two players.
// A round is opened with ready_p, choices are latched while sel_open is
// high, start_p judges the round, the outcome is held for REVEAL_CYCLES
// cycles, and the match ends when either player reaches WIN_SCORE points.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   ready_p, start_p  one-cycle pulses: open round / close and judge
//   a_sel, b_sel      one-hot choice pulses (100 rock, 010 scissors, 001 paper)
//   sel_open          high while choices are accepted
//   a_lock, b_lock    latched choices (000 = none)
//   result            00 none, 01 A wins, 10 B wins, 11 draw
//   result_vld        one-cycle pulse when result updates
//   incomplete        one-cycle pulse when start_p is rejected
//   score_a, score_b  points, saturating at WIN_SCORE
//   match_over        high once the match has been decided
module rps_match_ctrl #(
  parameter int WIN_SCORE     = 3,
  parameter int REVEAL_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready_p,
  input  logic       start_p,
  input  logic [2:0] a_sel,
  input  logic [2:0] b_sel,
  output logic       sel_open,
  output logic [2:0] a_lock,
  output logic [2:0] b_lock,
  output logic [1:0] result,
  output logic       result_vld,
  output logic       incomplete,
  output logic [3:0] score_a,
  output logic [3:0] score_b,
  output logic       match_over
);

  localparam int CW = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REVEAL_CYCLES - 1);
  localparam logic [3:0]    WIN      = 4'(WIN_SCORE);

  typedef enum logic [2:0] {IDLE, ARM, JUDGE, REVEAL, OVER} state_t;

  state_t          state, state_n;
  logic [2:0]      a_lock_n, b_lock_n;
  logic [1:0]      result_n;
  logic            result_vld_n, incomplete_n;
  logic [3:0]      score_a_n, score_b_n;
  logic [CW-1:0]   cnt, cnt_n;

  function automatic logic onehot3(input logic [2:0] s);
    return (s == 3'b100) || (s == 3'b010) || (s == 3'b001);
  endfunction

  // x beats y: rock>scissors, scissors>paper, paper>rock
  function automatic logic beats(input logic [2:0] x, input logic [2:0] y);
    return (x == 3'b100 && y == 3'b010) ||
           (x == 3'b010 && y == 3'b001) ||
           (x == 3'b001 && y == 3'b100);
  endfunction

  assign sel_open   = (state == ARM);
  assign match_over = (state == OVER);

  always_comb begin
    state_n      = state;
    a_lock_n     = a_lock;
    b_lock_n     = b_lock;
    result_n     = result;
    result_vld_n = 1'b0;
    incomplete_n = 1'b0;
    score_a_n    = score_a;
    score_b_n    = score_b;
    cnt_n        = cnt;
    unique case (state)
      IDLE: begin
        if (ready_p) begin
          state_n  = ARM;
          a_lock_n = '0;
          b_lock_n = '0;
          result_n = 2'b00;
        end
      end
      ARM: begin
        // ready_p outranks start_p, and neither cycle accepts a selection
        if (ready_p) begin
          a_lock_n = '0;
          b_lock_n = '0;
        end else if (start_p) begin
          if (a_lock != 3'b000 && b_lock != 3'b000) state_n = JUDGE;
          else                                       incomplete_n = 1'b1;
        end else begin
          if (onehot3(a_sel)) a_lock_n = a_sel;
          if (onehot3(b_sel)) b_lock_n = b_sel;
        end
      end
      JUDGE: begin
        state_n      = REVEAL;
        cnt_n        = '0;
        result_vld_n = 1'b1;
        if (a_lock == b_lock) begin
          result_n = 2'b11;
        end else if (beats(a_lock, b_lock)) begin
          result_n = 2'b01;
          if (score_a < WIN) score_a_n = score_a + 4'd1;
        end else begin
          result_n = 2'b10;
          if (score_b < WIN) score_b_n = score_b + 4'd1;
        end
      end
      REVEAL: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          state_n = (score_a == WIN || score_b == WIN) ? OVER : IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      OVER: ;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_lock     <= '0;
      b_lock     <= '0;
      result     <= '0;
      result_vld <= 1'b0;
      incomplete <= 1'b0;
      score_a    <= '0;
      score_b    <= '0;
      cnt        <= '0;
    end else begin
      state      <= state_n;
      a_lock     <= a_lock_n;
      b_lock     <= b_lock_n;
      result     <= result_n;
      result_vld <= result_vld_n;
      incomplete <= incomplete_n;
      score_a    <= score_a_n;
      score_b    <= score_b_n;
      cnt        <= cnt_n;
    end
  end

endmodule

// File: tb/tb_rps_match_ctrl.sv
module tb_rps_match_ctrl;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] S = 3'b010;
  localparam logic [2:0] P = 3'b001;

  logic       clk = 1'b0;
  logic       rst, ready_p, start_p;
  logic [2:0] a_sel, b_sel;
  logic       sel_open, result_vld, incomplete, match_over;
  logic [2:0] a_lock, b_lock;
  logic [1:0] result;
  logic [3:0] score_a, score_b;

  int errors = 0;
  int checks = 0;

  rps_match_ctrl #(.WIN_SCORE(3), .REVEAL_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .ready_p(ready_p), .start_p(start_p),
    .a_sel(a_sel), .b_sel(b_sel), .sel_open(sel_open),
    .a_lock(a_lock), .b_lock(b_lock), .result(result),
    .result_vld(result_vld), .incomplete(incomplete),
    .score_a(score_a), .score_b(score_b), .match_over(match_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rdy, st;
    logic [2:0] a, b;
    logic       so;
    logic [2:0] al, bl;
    logic [1:0] res;
    logic       rv, inc;
    logic [3:0] sa, sb;
    logic       mo;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic rdy, input logic st, input logic [2:0] a, input logic [2:0] b,
                     input logic so, input logic [2:0] al, input logic [2:0] bl,
                     input logic [1:0] res, input logic rv, input logic inc,
                     input logic [3:0] sa, input logic [3:0] sb, input logic mo);
    vec_t v;
    v.rdy = rdy; v.st = st; v.a = a; v.b = b;
    v.so = so; v.al = al; v.bl = bl; v.res = res; v.rv = rv; v.inc = inc;
    v.sa = sa; v.sb = sb; v.mo = mo;
    vt.push_back(v);
  endtask

  function automatic logic [19:0] outs();
    return {sel_open, a_lock, b_lock, result, result_vld, incomplete, score_a, score_b, match_over};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, sample 1 ns after the rising edge.
  task automatic cyc(input logic rs, input logic rd, input logic st,
                     input logic [2:0] a, input logic [2:0] b);
    @(negedge clk);
    rst = rs; ready_p = rd; start_p = st; a_sel = a; b_sel = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(); cyc(1'b0, 1'b0, 1'b0, 3'b000, 3'b000); endtask

  // Full round; checks the 2-cycle latency, the reveal hold and match_over timing.
  task automatic play(input string name, input logic [2:0] a, input logic [2:0] b,
                      input logic [1:0] res, input logic [3:0] sa, input logic [3:0] sb,
                      input logic over);
    cyc(1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
    cyc(1'b0, 1'b0, 1'b0, a, 3'b000);
    cyc(1'b0, 1'b0, 1'b0, 3'b000, b);
    cyc(1'b0, 1'b0, 1'b1, 3'b000, 3'b000);
    chk({name, "_judge_novld"}, 32'(result_vld), 32'd0);
    idle();
    chk({name, "_vld"}, {12'd0, outs()},
        {12'd0, 1'b0, a, b, res, 1'b1, 1'b0, sa, sb, 1'b0});
    for (int i = 1; i <= 3; i++) begin
      idle();
      chk({name, "_reveal"}, {28'd0, result_vld, match_over, result}, {28'd0, 1'b0, 1'b0, res});
    end
    idle();
    chk({name, "_end"}, {30'd0, match_over, sel_open}, {30'd0, over, 1'b0});
  endtask

  initial begin
    rst = 1'b1; ready_p = 1'b0; start_p = 1'b0; a_sel = '0; b_sel = '0;

    // Vectors: inputs for one cycle, then expected outputs after that edge.
    // Round 1: A rock vs B scissors, inputs ignored during reveal/idle
    add(1,0,0,0,       1,0,0,0,0,0,0,0,0);
    add(0,0,R,0,       1,R,0,0,0,0,0,0,0);
    add(0,0,0,S,       1,R,S,0,0,0,0,0,0);
    add(0,1,0,0,       0,R,S,0,0,0,0,0,0);
    add(0,0,0,0,       0,R,S,1,1,0,1,0,0);
    add(1,0,0,0,       0,R,S,1,0,0,1,0,0);
    add(0,1,P,P,       0,R,S,1,0,0,1,0,0);
    add(1,0,0,0,       0,R,S,1,0,0,1,0,0);
    add(1,0,0,0,       0,R,S,1,0,0,1,0,0);
    add(0,1,P,S,       0,R,S,1,0,0,1,0,0);
    // Round 2: incomplete start, then paper-paper draw
    add(1,0,0,0,       1,0,0,0,0,0,1,0,0);
    add(0,0,P,0,       1,P,0,0,0,0,1,0,0);
    add(0,1,0,0,       1,P,0,0,0,1,1,0,0);
    add(0,0,0,0,       1,P,0,0,0,0,1,0,0);
    add(0,0,0,P,       1,P,P,0,0,0,1,0,0);
    add(0,1,0,0,       0,P,P,0,0,0,1,0,0);
    add(0,0,0,0,       0,P,P,3,1,0,1,0,0);
    add(0,0,0,0,       0,P,P,3,0,0,1,0,0);
    add(0,0,0,0,       0,P,P,3,0,0,1,0,0);
    add(0,0,0,0,       0,P,P,3,0,0,1,0,0);
    add(0,0,0,0,       0,P,P,3,0,0,1,0,0);
    // Round 3: invalid selections, overwrite, re-arm priority, start-cycle selection ignored
    add(1,0,0,0,       1,0,0,0,0,0,1,0,0);
    add(0,0,3'b011,3'b110, 1,0,0,0,0,0,1,0,0);
    add(0,0,R,0,       1,R,0,0,0,0,1,0,0);
    add(0,0,S,3'b111,  1,S,0,0,0,0,1,0,0);
    add(0,0,0,R,       1,S,R,0,0,0,1,0,0);
    add(1,1,P,P,       1,0,0,0,0,0,1,0,0);
    add(0,0,0,0,       1,0,0,0,0,0,1,0,0);
    add(0,0,R,S,       1,R,S,0,0,0,1,0,0);
    add(0,1,P,P,       0,R,S,0,0,0,1,0,0);
    add(0,0,0,0,       0,R,S,1,1,0,2,0,0);
    add(0,0,0,0,       0,R,S,1,0,0,2,0,0);
    add(0,0,0,0,       0,R,S,1,0,0,2,0,0);
    add(0,0,0,0,       0,R,S,1,0,0,2,0,0);
    add(0,0,0,0,       0,R,S,1,0,0,2,0,0);

    cyc(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
    cyc(1'b1, 1'b1, 1'b1, R, S);
    chk("reset_state", {12'd0, outs()}, 32'd0);

    foreach (vt[i]) begin
      cyc(1'b0, vt[i].rdy, vt[i].st, vt[i].a, vt[i].b);
      chk($sformatf("vec%0d", i), {12'd0, outs()},
          {12'd0, vt[i].so, vt[i].al, vt[i].bl, vt[i].res, vt[i].rv, vt[i].inc,
           vt[i].sa, vt[i].sb, vt[i].mo});
    end

    // B wins three rounds in a row (rock>scissors, scissors>paper, paper>rock)
    play("b1", S, R, 2'b10, 4'd2, 4'd1, 1'b0);
    play("b2", P, S, 2'b10, 4'd2, 4'd2, 1'b0);
    play("b3", R, P, 2'b10, 4'd2, 4'd3, 1'b1);

    // OVER ignores everything
    cyc(1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
    cyc(1'b0, 1'b0, 1'b1, S, S);
    cyc(1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    chk("over_hold", {12'd0, outs()},
        {12'd0, 1'b0, R, P, 2'b10, 1'b0, 1'b0, 4'd2, 4'd3, 1'b1});

    // Reset out of OVER, then a normal round
    cyc(1'b1, 1'b1, 1'b0, R, S);
    chk("rst_over", {12'd0, outs()}, 32'd0);
    play("post_over", R, S, 2'b01, 4'd1, 4'd0, 1'b0);

    // Reset in the second reveal cycle
    cyc(1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
    cyc(1'b0, 1'b0, 1'b0, S, P);
    cyc(1'b0, 1'b0, 1'b1, 3'b000, 3'b000);
    idle();
    chk("mid_vld", {12'd0, outs()},
        {12'd0, 1'b0, S, P, 2'b01, 1'b1, 1'b0, 4'd2, 4'd0, 1'b0});
    idle();
    cyc(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
    chk("rst_reveal", {12'd0, outs()}, 32'd0);
    play("post_reveal", P, R, 2'b01, 4'd1, 4'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
